// File: rtl/id_fwd_pkg.sv
// Shared constants for the ID operand stage: operand width default,
// register-file address width and instruction register-field positions.
package id_fwd_pkg;

    localparam int XLEN_DEF = 64;
    localparam int RF_AW    = 5;
    localparam int RS1_LSB  = 15;
    localparam int RS2_LSB  = 20;
    localparam int RD_LSB   = 7;

    function automatic logic [RF_AW-1:0] rf_field(input logic [31:0] inst, input int lsb);
        return inst[lsb +: RF_AW];
    endfunction

endpackage

// File: rtl/id_fwd_stage_fwd_mux.sv
// Priority bypass mux for one source operand: the lowest-indexed (youngest)
// port writing the requested register wins, whether or not its data is ready.
module fwd_mux
    import id_fwd_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NFWD = 4
) (
    input  logic [RF_AW-1:0]      rs_i,
    input  logic [NFWD-1:0]       fwd_we_i,
    input  logic [NFWD-1:0]       fwd_rdy_i,
    input  logic [RF_AW*NFWD-1:0] fwd_waddr_i,
    input  logic [XLEN*NFWD-1:0]  fwd_wdata_i,
    output logic                  hit_o,
    output logic                  rdy_o,
    output logic [XLEN-1:0]       data_o
);

    // Walk oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        hit_o  = 1'b0;
        rdy_o  = 1'b0;
        data_o = '0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we_i[i] && (fwd_waddr_i[RF_AW*i +: RF_AW] == rs_i)) begin
                hit_o  = 1'b1;
                rdy_o  = fwd_rdy_i[i];
                data_o = fwd_wdata_i[XLEN*i +: XLEN];
            end
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode-side operand stage: IF2->ID register, rs1/rs2 bypass resolution,
// long-op busy scoreboard and hazard stall request.
module id_fwd_stage
    import id_fwd_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NFWD = 4,
    parameter int PC_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  stall_id,
    input  logic                  stall_ex,
    input  logic                  br_e,
    input  logic                  if_valid,
    input  logic [PC_W-1:0]       if_pc,
    input  logic [31:0]           if_inst,
    input  logic                  dec_use_rs1,
    input  logic                  dec_use_rs2,
    input  logic                  dec_rf_we,
    input  logic                  dec_long,
    output logic [RF_AW-1:0]      rf_raddr1,
    output logic [RF_AW-1:0]      rf_raddr2,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    input  logic [NFWD-1:0]       fwd_we,
    input  logic [NFWD-1:0]       fwd_rdy,
    input  logic [RF_AW*NFWD-1:0] fwd_waddr,
    input  logic [XLEN*NFWD-1:0]  fwd_wdata,
    input  logic                  lo_done,
    input  logic [RF_AW-1:0]      lo_waddr,
    output logic                  id_valid,
    output logic [PC_W-1:0]       id_pc,
    output logic [31:0]           id_inst,
    output logic [XLEN-1:0]       src1,
    output logic [XLEN-1:0]       src2,
    output logic                  stallreq_id,
    output logic [31:0]           stall_cnt
);

    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [31:0]     busy_q, busy_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic [RF_AW-1:0] rs1, rs2, rd;
    logic             hit1, rdy1, hit2, rdy2;
    logic [XLEN-1:0]  fdata1, fdata2;
    logic             hz1, hz2, hz_sb1, hz_sb2, hz_waw, issue_long;

    assign rs1 = rf_field(inst_q, RS1_LSB);
    assign rs2 = rf_field(inst_q, RS2_LSB);
    assign rd  = rf_field(inst_q, RD_LSB);

    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd1 (
        .rs_i(rs1), .fwd_we_i(fwd_we), .fwd_rdy_i(fwd_rdy),
        .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
        .hit_o(hit1), .rdy_o(rdy1), .data_o(fdata1)
    );

    fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd2 (
        .rs_i(rs2), .fwd_we_i(fwd_we), .fwd_rdy_i(fwd_rdy),
        .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata),
        .hit_o(hit2), .rdy_o(rdy2), .data_o(fdata2)
    );

    // x0 is never forwarded and never hazards, whatever a port claims to write.
    assign src1 = (rs1 == '0) ? '0 : (hit1 ? fdata1 : rf_rdata1);
    assign src2 = (rs2 == '0) ? '0 : (hit2 ? fdata2 : rf_rdata2);

    assign hz1    = (rs1 != '0) && hit1 && !rdy1;
    assign hz2    = (rs2 != '0) && hit2 && !rdy2;
    assign hz_sb1 = busy_q[rs1] && !(lo_done && lo_waddr == rs1) && !(hit1 && rdy1);
    assign hz_sb2 = busy_q[rs2] && !(lo_done && lo_waddr == rs2) && !(hit2 && rdy2);
    assign hz_waw = dec_rf_we && (rd != '0) && busy_q[rd] && !(lo_done && lo_waddr == rd);

    assign stallreq_id = valid_q && ((dec_use_rs1 && (hz1 || hz_sb1)) ||
                                     (dec_use_rs2 && (hz2 || hz_sb2)) || hz_waw);
    assign id_valid    = valid_q && !stallreq_id && !flush;
    assign issue_long  = id_valid && !stall_ex && dec_long && dec_rf_we && (rd != '0);

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;
    assign id_pc     = pc_q;
    assign id_inst   = inst_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        busy_d      = busy_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            inst_d  = '0;
        end else if (stall_id) begin
            valid_d = valid_q;
        end else if (br_e) begin
            valid_d = 1'b0;
            pc_d    = '0;
            inst_d  = '0;
        end else begin
            valid_d = if_valid;
            pc_d    = if_pc;
            inst_d  = if_inst;
        end

        // Set after clear so a back-to-back long op to the same rd stays busy.
        if (flush) begin
            busy_d = '0;
        end else begin
            if (lo_done) busy_d[lo_waddr] = 1'b0;
            if (issue_long) busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (stallreq_id && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            inst_q      <= '0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: forwarding priority, x0, scoreboard RAW/WAW,
// flush, stall/branch-kill ordering and reset during a stall.
module tb_id_fwd_stage;
    import id_fwd_pkg::*;

    localparam int XLEN = 64;
    localparam int NFWD = 4;
    localparam int PC_W = 32;

    localparam logic [31:0] I_ADD_A0  = 32'h00B5_0533; // add a0,a0,a1
    localparam logic [31:0] I_ADD_X0  = 32'h00B0_0533; // add a0,x0,a1
    localparam logic [31:0] I_MUL_T0  = 32'h02B5_02B3; // mul t0,a0,a1
    localparam logic [31:0] I_RD_T0   = 32'h00B2_8533; // add a0,t0,a1
    localparam logic [31:0] I_WR_T0   = 32'h00B5_02B3; // add t0,a0,a1

    logic clk = 1'b0;
    logic rst_n, flush, stall_id, stall_ex, br_e, if_valid;
    logic [PC_W-1:0] if_pc;
    logic [31:0] if_inst;
    logic dec_use_rs1, dec_use_rs2, dec_rf_we, dec_long;
    logic [RF_AW-1:0] rf_raddr1, rf_raddr2;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic [NFWD-1:0] fwd_we, fwd_rdy;
    logic [RF_AW*NFWD-1:0] fwd_waddr;
    logic [XLEN*NFWD-1:0] fwd_wdata;
    logic lo_done;
    logic [RF_AW-1:0] lo_waddr;
    logic id_valid, stallreq_id;
    logic [PC_W-1:0] id_pc;
    logic [31:0] id_inst, stall_cnt;
    logic [XLEN-1:0] src1, src2;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    id_fwd_stage #(.XLEN(XLEN), .NFWD(NFWD), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall_id(stall_id),
        .stall_ex(stall_ex), .br_e(br_e), .if_valid(if_valid), .if_pc(if_pc),
        .if_inst(if_inst), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rf_we(dec_rf_we), .dec_long(dec_long), .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_rdy(fwd_rdy), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .lo_done(lo_done), .lo_waddr(lo_waddr),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .src1(src1),
        .src2(src2), .stallreq_id(stallreq_id), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input int p, input logic we, input logic rdy,
                           input logic [4:0] wa, input logic [63:0] wd);
        fwd_we[p]             = we;
        fwd_rdy[p]            = rdy;
        fwd_waddr[5*p +: 5]   = wa;
        fwd_wdata[64*p +: 64] = wd;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall_id = 1'b0; stall_ex = 1'b0; br_e = 1'b0;
        if_valid = 1'b0; if_pc = '0; if_inst = '0;
        dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_rf_we = 1'b0; dec_long = 1'b0;
        rf_rdata1 = 64'hAAAA; rf_rdata2 = 64'hBBBB;
        fwd_we = '0; fwd_rdy = '0; fwd_waddr = '0; fwd_wdata = '0;
        lo_done = 1'b0; lo_waddr = '0;
        tick(); tick();
        chk("rst_valid", id_valid, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_inst", id_inst, 0);
        chk("rst_cnt", stall_cnt, 0);
        rst_n = 1'b1;

        // plain load, no forwarding
        if_valid = 1'b1; if_pc = 32'h8000_0000; if_inst = I_ADD_A0;
        dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; dec_rf_we = 1'b1;
        tick(); #1;
        chk("ld_valid", id_valid, 1);
        chk("ld_pc", id_pc, 32'h8000_0000);
        chk("ld_inst", id_inst, I_ADD_A0);
        chk("ld_raddr1", rf_raddr1, 10);
        chk("ld_raddr2", rf_raddr2, 11);
        chk("ld_src1", src1, 64'hAAAA);
        chk("ld_src2", src2, 64'hBBBB);
        chk("ld_stall", stallreq_id, 0);

        // youngest port wins; not-ready youngest stalls despite ready older port
        set_fwd(0, 1'b1, 1'b1, 5'd10, 64'h11);
        set_fwd(2, 1'b1, 1'b1, 5'd10, 64'h22);
        #1;
        chk("fwd_src1", src1, 64'h11);
        chk("fwd_src2", src2, 64'hBBBB);
        chk("fwd_nostall", stallreq_id, 0);
        fwd_rdy[0] = 1'b0;
        #1;
        chk("lu_stall", stallreq_id, 1);
        chk("lu_valid", id_valid, 0);
        tick(); exp_cnt++;
        chk("lu_cnt1", stall_cnt, exp_cnt);
        tick(); exp_cnt++;
        chk("lu_cnt2", stall_cnt, exp_cnt);
        fwd_we = '0;

        // x0 source ignores a port writing x0
        if_inst = I_ADD_X0;
        tick();
        set_fwd(0, 1'b1, 1'b1, 5'd0, 64'hFF);
        #1;
        chk("x0_src1", src1, 0);
        chk("x0_stall", stallreq_id, 0);
        chk("x0_valid", id_valid, 1);
        fwd_we = '0;

        // mul to x5 then a reader of x5: RAW on scoreboard
        if_inst = I_MUL_T0;
        tick();
        dec_long = 1'b1; #1;
        chk("mul_valid", id_valid, 1);
        if_inst = I_RD_T0;
        tick();
        dec_long = 1'b0; #1;
        chk("raw_stall", stallreq_id, 1);
        chk("raw_valid", id_valid, 0);
        tick(); exp_cnt++;
        chk("raw_cnt", stall_cnt, exp_cnt);
        lo_done = 1'b1; lo_waddr = 5'd5; #1;
        chk("raw_rel_stall", stallreq_id, 0);
        chk("raw_rel_valid", id_valid, 1);
        tick();
        lo_done = 1'b0; #1;
        chk("raw_clear", stallreq_id, 0);

        // WAW: mul t0 followed by a non-long write to t0
        if_inst = I_MUL_T0;
        tick();
        dec_long = 1'b1; #1;
        chk("waw_mul_valid", id_valid, 1);
        if_inst = I_WR_T0;
        tick();
        dec_long = 1'b0; #1;
        chk("waw_stall", stallreq_id, 1);
        tick(); exp_cnt++;

        // lo_done(x5) and a new long issue to x5 in the same cycle
        lo_done = 1'b1; lo_waddr = 5'd5; dec_long = 1'b1; #1;
        chk("sc_valid", id_valid, 1);
        tick();
        lo_done = 1'b0; dec_long = 1'b0; #1;
        chk("sc_busy_kept", stallreq_id, 1);
        flush = 1'b1; #1;
        chk("fl_valid", id_valid, 0);
        tick(); exp_cnt++;
        flush = 1'b0; #1;
        chk("fl_vq", id_valid, 0);
        chk("fl_inst", id_inst, 0);
        chk("fl_stall", stallreq_id, 0);
        chk("fl_cnt", stall_cnt, exp_cnt);
        tick();
        chk("fl_busy_clr", stallreq_id, 0);
        chk("fl_reload", id_valid, 1);

        // stall_id beats br_e; then br_e alone kills
        if_pc = 32'h8000_0004; if_inst = I_ADD_A0;
        stall_id = 1'b1; br_e = 1'b1;
        tick();
        chk("hold_pc", id_pc, 32'h8000_0000);
        chk("hold_inst", id_inst, I_WR_T0);
        chk("hold_valid", id_valid, 1);
        stall_id = 1'b0;
        tick();
        chk("kill_valid", id_valid, 0);
        chk("kill_inst", id_inst, 0);
        chk("kill_pc", id_pc, 0);
        br_e = 1'b0;
        tick();
        chk("post_kill_pc", id_pc, 32'h8000_0004);

        // reset during a hazard stall clears everything
        set_fwd(0, 1'b1, 1'b0, 5'd10, 64'h33);
        stall_id = 1'b1; #1;
        chk("pre_rst_stall", stallreq_id, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", id_valid, 0);
        chk("mid_rst_pc", id_pc, 0);
        chk("mid_rst_cnt", stall_cnt, 0);
        rst_n = 1'b1; stall_id = 1'b0; fwd_we = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_fwd_stage.md
Name: id_fwd_stage

Overview:
- Parametrised decode-side operand stage for the RV64 in-order pipeline, generalising the fixed four-source ID forwarding.
- Owns the IF2→ID pipeline register with stall, flush and branch-kill handling.
- Resolves rs1/rs2 through NFWD prioritised forwarding ports that carry per-port data-ready flags, so load-use hazards stall instead of forwarding stale data.
- Keeps a 32-entry busy scoreboard for multi-cycle mul/div results; raises stallreq_id on unresolved RAW or WAW hazards.

Parameters:
XLEN, 64, register/operand width
NFWD, 4, number of forwarding ports; index 0 is youngest (EX) and has highest priority
PC_W, 32, PC width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  pipeline flush (exception/redirect)
stall_id  in  1  ID hold from stall controller
stall_ex  in  1  EX hold from stall controller
br_e  in  1  taken branch resolved; kill instruction entering ID
if_valid  in  1  IF2 slot valid
if_pc  in  PC_W  IF2 PC
if_inst  in  32  IF2 instruction
dec_use_rs1  in  1  decoder: instruction reads rs1
dec_use_rs2  in  1  decoder: instruction reads rs2
dec_rf_we  in  1  decoder: instruction writes rd
dec_long  in  1  decoder: multi-cycle op (mul/div)
rf_raddr1  out  5  regfile read address 1 (inst[19:15])
rf_raddr2  out  5  regfile read address 2 (inst[24:20])
rf_rdata1  in  XLEN  regfile read data 1
rf_rdata2  in  XLEN  regfile read data 2
fwd_we  in  NFWD  per-port write enable
fwd_rdy  in  NFWD  per-port data valid (0 = load/long op still pending)
fwd_waddr  in  5*NFWD  per-port destination, port i at [5i+4:5i]
fwd_wdata  in  XLEN*NFWD  per-port data, port i at [XLEN*i+XLEN-1:XLEN*i]
lo_done  in  1  long op writes back this cycle
lo_waddr  in  5  long op destination
id_valid  out  1  instruction issued to EX this cycle
id_pc  out  PC_W  registered PC
id_inst  out  32  registered instruction (drives the decoder)
src1  out  XLEN  resolved rs1 operand
src2  out  XLEN  resolved rs2 operand
stallreq_id  out  1  hazard stall request
stall_cnt  out  32  saturating count of cycles with stallreq_id=1

Behaviour:
- Reset (synchronous, rst_n=0 at clk edge): valid_r=0, pc_r=0, inst_r=0, busy=0, stall_cnt=0.
- IF/ID register update order, first match wins: !rst_n or flush → clear; stall_id → hold; br_e → clear (bubble); else load {if_valid, if_pc, if_inst}.
- Reset asserted mid-stall clears everything; stall state is never retained across reset.
- Operand resolution for rs1 (rs2 identical):
  - rs=0 → src=0, no hazard.
  - Otherwise take the lowest index i with fwd_we[i] & fwd_waddr_i==rs.
  - If a match exists: src = fwd_wdata_i; hazard = !fwd_rdy[i]. A younger not-ready match is never bypassed by an older ready one.
  - If no match: src = rf_rdata.
- Scoreboard hazard for rs: hz_sb = busy[rs] & !(lo_done & lo_waddr==rs) & no ready forwarding match.
- stallreq_id = valid_r & ( (dec_use_rs1 & (hz1 | hz_sb1)) | (dec_use_rs2 & (hz2 | hz_sb2)) | (dec_rf_we & rd≠0 & busy[rd] & !(lo_done & lo_waddr==rd)) ). The last term is the WAW check.
- id_valid = valid_r & !stallreq_id & !flush. All outputs are combinational from the registered state; latency IF2→ID is one cycle.
- Scoreboard update per cycle:
  - flush → busy=0. The execute unit suppresses lo_done for killed ops.
  - Otherwise clear busy[lo_waddr] on lo_done.
  - Then set busy[rd] on issue = id_valid & !stall_ex & dec_long & dec_rf_we & rd≠0. Set wins over clear on the same register.
  - busy[0] is constant 0.
- stall_cnt increments when stallreq_id=1 and saturates at 32'hFFFF_FFFF; only reset clears it.

Decomposition:
- Shared package/define file holds XLEN default, RF_AW=5, and the rs1/rs2/rd bit-slice constants.
- One sub-module, fwd_mux: a per-operand priority mux over NFWD ports returning {hit, rdy, data}. Instantiate it twice.
- The scoreboard stays inline.

Test Plan:
- Reset, then load pc=0x80000000 inst=0x00B50533 (add a0,a0,a1) with no forwarding → id_valid=1 next cycle, src1=rf_rdata1, src2=rf_rdata2, stallreq_id=0.
- Port0 {we=1, waddr=10, rdy=1, data=0x11} and port2 {waddr=10, data=0x22} → src1=0x11; with port0 rdy=0 → stallreq_id=1, id_valid=0, stall_cnt increments each cycle.
- Read of x0 while fwd port0 writes x0 with data 0xFF → src1=0, no stall.
- Issue mul to x5 (dec_long=1), next instruction reads x5 → stall until lo_done with lo_waddr=5, released in that same cycle; also check WAW stall for a following write to x5.
- Simultaneous lo_done(x5) and new long issue to x5 → busy[5] remains 1; flush → busy=0 and valid_r=0 next cycle.
- stall_id=1 with br_e=1 → register holds; next cycle stall_id=0, br_e=1 → register cleared, id_valid=0.
